// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage and a DMA/loader port.
// Define DMEM_ARB_STARVE_GUARD_EN to enable the starvation guard (forced DMA slot).
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS   = 9,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p_req,
  input  logic                  p_we,
  input  logic [DM_ADDRESS-1:0] p_addr,
  input  logic [DATA_W-1:0]     p_wdata,
  input  logic [2:0]            p_func3,
  output logic [DATA_W-1:0]     p_rdata,
  output logic                  p_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DM_ADDRESS-1:0] d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic pipe_sel;
  logic dma_sel;
  logic stall;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  typedef enum logic [0:0] {StPipeOwn, StDmaSlot} state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;

  always_comb begin
    state_d  = StPipeOwn;
    starve_d = 4'd0;
    pipe_sel = 1'b0;
    dma_sel  = 1'b0;
    stall    = 1'b0;
    if (state_q == StDmaSlot && d_req) begin
      dma_sel = 1'b1;
      stall   = 1'b1;
    end else if (p_req) begin
      // An abandoned DMA slot (d_req dropped) falls through here as a normal cycle
      pipe_sel = 1'b1;
      if (d_req) begin
        starve_d = starve_q + 4'd1;
        if (starve_d == 4'(STARVE_LIMIT)) begin
          state_d = StDmaSlot;
        end
      end
    end else if (d_req) begin
      dma_sel = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StPipeOwn;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    pipe_sel = p_req;
    dma_sel  = ~p_req & d_req;
    stall    = 1'b0;
  end
`endif

  assign d_gnt     = dma_sel & ~reset;
  assign p_stall   = stall & ~reset;
  assign mem_rd    = ~reset & ((pipe_sel & ~p_we) | (dma_sel & ~d_we));
  assign mem_wr    = ~reset & ((pipe_sel & p_we) | (dma_sel & d_we));
  assign mem_addr  = dma_sel ? d_addr : p_addr;
  assign mem_wdata = dma_sel ? d_wdata : p_wdata;
  assign mem_func3 = dma_sel ? 3'b010 : p_func3;
  assign p_rdata   = mem_rdata;

  logic [DATA_W-1:0] d_rdata_q;
  logic              d_rvalid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
    end else begin
      d_rvalid_q <= d_gnt & ~d_we;
      if (d_gnt && !d_we) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  assign d_rdata  = d_rdata_q;
  assign d_rvalid = d_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; expectations follow
// DMEM_ARB_STARVE_GUARD_EN when the bench is built with it defined.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_we, d_req, d_we;
  logic [8:0]  p_addr, d_addr, mem_addr;
  logic [31:0] p_wdata, d_wdata, p_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [2:0]  p_func3, mem_func3;
  logic        p_stall, d_gnt, d_rvalid, mem_rd, mem_wr;
  logic [31:0] mem_arr [0:511];

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_func3(p_func3),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  // Simple memory model: combinational read, write on the rising edge
  assign mem_rdata = mem_arr[mem_addr];
  always @(posedge clk) if (mem_wr) mem_arr[mem_addr] <= mem_wdata;

  task automatic idle();
    @(negedge clk);
    p_req = 1'b0;
    d_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    p_req = 1'b1; p_we = 1'b1; d_req = 1'b1; d_we = 1'b1;
    #1;
    vec_cnt++; if (d_gnt !== 1'b0) begin miss_cnt++;
      $display("FAIL reset_d_gnt got %b want 0", d_gnt); end
    vec_cnt++; if (p_stall !== 1'b0) begin miss_cnt++;
      $display("FAIL reset_p_stall got %b want 0", p_stall); end
    vec_cnt++; if ({mem_rd, mem_wr} !== 2'b00) begin miss_cnt++;
      $display("FAIL reset_mem_en got %b want 00", {mem_rd, mem_wr}); end
    @(posedge clk);
    #1;
    vec_cnt++; if (d_rvalid !== 1'b0) begin miss_cnt++;
      $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); end
    vec_cnt++; if (d_rdata !== 32'h0) begin miss_cnt++;
      $display("FAIL reset_d_rdata got %h want 0", d_rdata); end
    @(negedge clk);
    reset = 1'b0;
    p_req = 1'b0; d_req = 1'b0; p_we = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_dma_read();
    idle();
    mem_arr[9'h040] = 32'hCAFE_0001;
    @(negedge clk);
    p_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 9'h040;
    #1;
    vec_cnt++; if (d_gnt !== 1'b1) begin miss_cnt++;
      $display("FAIL dma_rd_gnt got %b want 1", d_gnt); end
    vec_cnt++; if ({mem_rd, mem_wr} !== 2'b10) begin miss_cnt++;
      $display("FAIL dma_rd_en got %b want 10", {mem_rd, mem_wr}); end
    vec_cnt++; if (mem_addr !== 9'h040 || mem_func3 !== 3'b010) begin miss_cnt++;
      $display("FAIL dma_rd_fields got %h/%b want 040/010", mem_addr, mem_func3); end
    @(posedge clk);
    #1;
    vec_cnt++; if (d_rvalid !== 1'b1) begin miss_cnt++;
      $display("FAIL dma_rd_rvalid got %b want 1", d_rvalid); end
    vec_cnt++; if (d_rdata !== 32'hCAFE_0001) begin miss_cnt++;
      $display("FAIL dma_rd_rdata got %h want cafe0001", d_rdata); end
    idle();
    vec_cnt++; if (d_rvalid !== 1'b0 || d_rdata !== 32'hCAFE_0001) begin miss_cnt++;
      $display("FAIL dma_rd_hold got %b/%h want 0/cafe0001", d_rvalid, d_rdata); end
  endtask

  task automatic test_pipe_write();
    @(negedge clk);
    p_req = 1'b1; p_we = 1'b1; p_addr = 9'h010; p_wdata = 32'hA5A5_0F0F; p_func3 = 3'b001;
    d_req = 1'b0;
    #1;
    vec_cnt++; if ({mem_rd, mem_wr} !== 2'b01) begin miss_cnt++;
      $display("FAIL pipe_wr_en got %b want 01", {mem_rd, mem_wr}); end
    vec_cnt++; if (mem_addr !== 9'h010 || mem_wdata !== 32'hA5A5_0F0F) begin miss_cnt++;
      $display("FAIL pipe_wr_fields got %h/%h want 010/a5a50f0f", mem_addr, mem_wdata); end
    vec_cnt++; if (mem_func3 !== 3'b001) begin miss_cnt++;
      $display("FAIL pipe_wr_func3 got %b want 001", mem_func3); end
    vec_cnt++; if (d_gnt !== 1'b0 || p_stall !== 1'b0) begin miss_cnt++;
      $display("FAIL pipe_wr_gnt_stall got %b%b want 00", d_gnt, p_stall); end
    @(posedge clk);
    #1;
    p_we = 1'b0;
  endtask

  task automatic test_idle();
    @(negedge clk);
    p_req = 1'b0; d_req = 1'b0; p_we = 1'b1; d_we = 1'b1;
    #1;
    vec_cnt++; if ({mem_rd, mem_wr, d_gnt, p_stall} !== 4'b0000) begin miss_cnt++;
      $display("FAIL idle_outputs got %b want 0000", {mem_rd, mem_wr, d_gnt, p_stall}); end
    @(posedge clk);
    #1;
    p_we = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_dma_write_read();
    idle();
    @(negedge clk);
    p_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 9'h100; d_wdata = 32'h1234_5678;
    #1;
    vec_cnt++; if (d_gnt !== 1'b1 || {mem_rd, mem_wr} !== 2'b01) begin miss_cnt++;
      $display("FAIL dma_wr_en got gnt=%b en=%b want 1/01", d_gnt, {mem_rd, mem_wr}); end
    vec_cnt++; if (mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h100) begin miss_cnt++;
      $display("FAIL dma_wr_fields got %h/%h want 100/12345678", mem_addr, mem_wdata); end
    @(posedge clk);
    #1;
    vec_cnt++; if (d_rvalid !== 1'b0) begin miss_cnt++;
      $display("FAIL dma_wr_rvalid got %b want 0", d_rvalid); end
    @(negedge clk);
    d_we = 1'b0;
    #1;
    vec_cnt++; if (d_gnt !== 1'b1 || mem_rd !== 1'b1) begin miss_cnt++;
      $display("FAIL dma_rb_en got gnt=%b rd=%b want 1/1", d_gnt, mem_rd); end
    @(posedge clk);
    #1;
    vec_cnt++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1234_5678) begin miss_cnt++;
      $display("FAIL dma_rb_data got %b/%h want 1/12345678", d_rvalid, d_rdata); end
    idle();
  endtask

  // Runs n contended read cycles; a slot is expected on cycle slot_at (guard builds only)
  task automatic contend(input int n, input int slot_at, input string tag);
    for (int i = 0; i < n; i++) begin
      logic slot;
      slot = Guard && ((i % 5) == slot_at);
      @(negedge clk);
      p_req = 1'b1; p_we = 1'b0; p_addr = 9'h020;
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h044;
      #1;
      vec_cnt++; if (d_gnt !== slot || p_stall !== slot) begin miss_cnt++;
        $display("FAIL %s_gnt_stall[%0d] got %b%b want %b%b", tag, i, d_gnt, p_stall,
                 slot, slot); end
      vec_cnt++; if (mem_addr !== (slot ? 9'h044 : 9'h020) || mem_rd !== 1'b1) begin
        miss_cnt++;
        $display("FAIL %s_addr[%0d] got %h rd=%b", tag, i, mem_addr, mem_rd); end
      @(posedge clk);
      #1;
      vec_cnt++; if (d_rvalid !== slot) begin miss_cnt++;
        $display("FAIL %s_rvalid[%0d] got %b want %b", tag, i, d_rvalid, slot); end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    mem_arr[9'h020] = 32'h5555_AAAA;
    contend(3, 99, "pre_rst");
    @(negedge clk);
    p_we = 1'b1; p_wdata = 32'hDEAD_BEEF;
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++; if ({d_gnt, p_stall, mem_rd, mem_wr} !== 4'b0000) begin miss_cnt++;
      $display("FAIL midrst_comb got %b want 0000", {d_gnt, p_stall, mem_rd, mem_wr}); end
    vec_cnt++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin miss_cnt++;
      $display("FAIL midrst_regs got %b/%h want 0/0", d_rvalid, d_rdata); end
    @(posedge clk);
    #1;
    vec_cnt++; if (mem_arr[9'h020] !== 32'h5555_AAAA) begin miss_cnt++;
      $display("FAIL midrst_no_write got %h want 5555aaaa", mem_arr[9'h020]); end
    @(negedge clk);
    reset = 1'b0;
    p_we = 1'b0;
    contend(5, 4, "post_rst");
    idle();
  endtask

  task automatic test_starve();
    idle();
    contend(20, 4, "starve");
    idle();
  endtask

  task automatic test_slot_no_dma();
    idle();
    contend(4, 99, "pre_slot");
    @(negedge clk);
    p_req = 1'b1; p_we = 1'b1; p_addr = 9'h030; p_wdata = 32'h0BAD_F00D; d_req = 1'b0;
    #1;
    vec_cnt++; if ({d_gnt, p_stall, mem_wr} !== 3'b001 || mem_addr !== 9'h030) begin
      miss_cnt++;
      $display("FAIL slot_nodma got gnt/stall/wr=%b addr=%h want 001/030",
               {d_gnt, p_stall, mem_wr}, mem_addr); end
    @(posedge clk);
    #1;
    contend(5, 4, "after_slot");
    idle();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem_arr[i] = 32'h0;
    reset = 1'b1;
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; p_func3 = 3'b010;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_dma_read();
    test_pipe_write();
    test_idle();
    test_dma_write_read();
    test_reset_mid();
    test_starve();
    test_slot_no_dma();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
